// File: rtl/neuron_out_stage.sv
// neuron_out_stage: captures hidden-layer neuron outputs on a fixed latency, clamps and classifies them,
// and buffers them in a credit-controlled FIFO with valid/ready output and debug counters.
module neuron_out_stage #(
  parameter int          NEURON_LAT = 2,
  parameter int          DEPTH      = 4,
  parameter logic [10:0] THRESH     = 11'd512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [10:0] n0_out,
  input  logic [10:0] n1_out,
  input  logic [10:0] n2_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_act0,
  output logic [9:0]  out_act1,
  output logic [9:0]  out_act2,
  output logic [2:0]  out_class,
  output logic [2:0]  out_sat,
  output logic [15:0] sample_cnt,
  output logic [15:0] sat_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [NEURON_LAT-1:0] r_inflight;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [35:0]           r_mem [DEPTH];
  logic [15:0]           r_sample_cnt, r_sat_cnt;
  logic [5:0]            w_credit_used;
  logic [32:0]           w_n;
  logic [2:0]            w_sat, w_cls;
  logic [29:0]           w_act;
  logic                  w_issue, w_capture, w_pop;
  // Credit counts both buffered entries and evaluations still inside the neuron pipeline.
  always_comb begin
    w_credit_used = 6'(r_count);
    for (int i = 0; i < NEURON_LAT; i++) w_credit_used = w_credit_used + 6'(r_inflight[i]);
  end
  assign issue_ready = w_credit_used < 6'(DEPTH);
  assign w_issue     = issue_valid && issue_ready;
  assign w_capture   = r_inflight[NEURON_LAT-1];
  assign out_valid   = r_count != '0;
  assign w_pop       = out_valid && out_ready;
  assign w_n         = {n2_out, n1_out, n0_out};
  // Anything above 1023 has bit 10 set, so that bit is the clamp flag.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_sat[i]          = w_n[11*i+10];
      w_cls[i]          = w_n[11*i +: 11] >= THRESH;
      w_act[10*i +: 10] = w_sat[i] ? 10'h3FF : w_n[11*i +: 10];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_sample_cnt <= '0;
      r_sat_cnt    <= '0;
    end else begin
      r_inflight <= (r_inflight << 1) | NEURON_LAT'(w_issue);
      r_count    <= r_count + CW'(w_capture) - CW'(w_pop);
      if (w_capture) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_pop) r_sample_cnt <= r_sample_cnt + 16'd1;
      if (w_capture && |w_sat && r_sat_cnt != 16'hFFFF) r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_capture) r_mem[r_wr_ptr] <= {w_sat, w_cls, w_act};
  end
  always_comb {out_sat, out_class, out_act2, out_act1, out_act0} = out_valid ? r_mem[r_rd_ptr] : 36'h0;
  assign sample_cnt = r_sample_cnt;
  assign sat_cnt    = r_sat_cnt;
  always_ff @(posedge clk) begin
    assert (rst || !(w_capture && r_count == CW'(DEPTH)));
  end
endmodule

// File: tb/tb_neuron_out_stage.sv
// tb_neuron_out_stage: randomized scenario tests of neuron_out_stage against a queue-based model.
module tb_neuron_out_stage;
  localparam int LAT = 2;
  localparam int DEPTH = 4;
  logic        clk = 0, rst = 1, issue_valid = 0, out_ready = 0;
  logic        issue_ready, out_valid;
  logic [10:0] n0_out, n1_out, n2_out;
  logic [9:0]  out_act0, out_act1, out_act2;
  logic [2:0]  out_class, out_sat;
  logic [15:0] sample_cnt, sat_cnt;
  logic [35:0] got;
  logic [32:0] x = '0;
  logic [32:0] d [LAT];
  int total = 0, bad = 0;

  neuron_out_stage #(.NEURON_LAT(LAT), .DEPTH(DEPTH), .THRESH(11'd512)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .n0_out(n0_out), .n1_out(n1_out), .n2_out(n2_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_act0(out_act0), .out_act1(out_act1), .out_act2(out_act2),
    .out_class(out_class), .out_sat(out_sat), .sample_cnt(sample_cnt), .sat_cnt(sat_cnt));

  always #5 clk = ~clk;
  assign got = {out_sat, out_class, out_act2, out_act1, out_act0};

  // neuron pipeline stand-in: upstream values reappear LAT cycles later
  always @(posedge clk) begin
    d[0] <= x;
    for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
  end
  assign {n2_out, n1_out, n0_out} = d[LAT-1];

  typedef struct { int due; logic [32:0] v; } pend_t;
  pend_t       pend[$];
  logic [35:0] expq[$];
  int          cyc = 0;
  logic [15:0] m_samp = 0;
  int          m_sat = 0;

  function automatic logic [35:0] expect_of(logic [32:0] v);
    logic [2:0] s, c;
    logic [29:0] a;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = int'(v[11*i +: 11]);
      s[i] = n > 1023;
      c[i] = n >= 512;
      a[10*i +: 10] = 10'(n > 1023 ? 1023 : n);
    end
    return {s, c, a};
  endfunction

  function automatic logic [35:0] exp_head();
    return expq.size() > 0 ? expq[0] : 36'h0;
  endfunction

  function automatic logic exp_ready();
    return (expq.size() + pend.size()) < DEPTH;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      expq.delete();
      m_samp = 0;
      m_sat = 0;
    end else begin
      logic pop, iss;
      logic [35:0] e;
      pop = out_ready && expq.size() > 0;
      iss = issue_valid && (expq.size() + pend.size() < DEPTH);
      if (pop) begin
        void'(expq.pop_front());
        m_samp++;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = expect_of(pend[0].v);
        expq.push_back(e);
        if (|e[35:33] && m_sat < 65535) m_sat++;
        void'(pend.pop_front());
      end
      if (iss) pend.push_back('{cyc + LAT, x});
    end
    cyc++;
  end

  function automatic logic [10:0] pick();
    logic [10:0] corners [6] = '{11'd0, 11'd511, 11'd512, 11'd1023, 11'd1024, 11'd2047};
    int r;
    r = $urandom_range(0, 7);
    return r < 6 ? corners[r] : 11'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; issue_valid = 0; out_ready = 0;
    repeat (2) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (got !== 36'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", got); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    total++; if (sample_cnt !== 16'd0 || sat_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", sample_cnt, sat_cnt); end
    rst = 0;
    tick();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", issue_ready); end
  endtask

  task automatic test_single();
    issue_valid = 1; out_ready = 1; x = {11'd0, 11'd600, 11'd5};
    tick();
    issue_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      x = {pick(), pick(), pick()};
      total++; if (out_valid !== (k == 3)) begin bad++; $display("FAIL single_latency k=%0d got=%b exp=%b", k, out_valid, k == 3); end
      if (k < 3) tick();
    end
    total++; if (got !== {3'b000, 3'b010, 10'd0, 10'd600, 10'd5}) begin bad++; $display("FAIL single_data got=%h exp=%h", got, {3'b000, 3'b010, 10'd0, 10'd600, 10'd5}); end
    total++; if (got !== exp_head()) begin bad++; $display("FAIL single_model got=%h exp=%h", got, exp_head()); end
    tick();
    total++; if (out_valid !== 1'b0 || sample_cnt !== 16'd1) begin bad++; $display("FAIL single_pop got=%b/%0d exp=0/1", out_valid, sample_cnt); end
  endtask

  task automatic test_sat();
    out_ready = 0; issue_valid = 1; x = {11'd1024, 11'd1023, 11'd2047};
    tick();
    issue_valid = 0;
    repeat (2) tick();
    total++; if (got !== {3'b101, 3'b111, 30'h3FFFFFFF}) begin bad++; $display("FAIL sat_data got=%h exp=%h", got, {3'b101, 3'b111, 30'h3FFFFFFF}); end
    total++; if (sat_cnt !== 16'd1 || sat_cnt !== 16'(m_sat)) begin bad++; $display("FAIL sat_cnt got=%0d exp=1", sat_cnt); end
    out_ready = 1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sat_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_full();
    int accepted = 0;
    logic [35:0] head = '0;
    out_ready = 0; issue_valid = 1;
    for (int k = 0; k < 10; k++) begin
      x = {pick(), pick(), pick()};
      total++; if (issue_ready !== exp_ready()) begin bad++; $display("FAIL full_ready k=%0d got=%b exp=%b", k, issue_ready, exp_ready()); end
      accepted += int'(issue_ready);
      tick();
      if (k == 5) begin
        head = exp_head();
        total++; if (got !== head || out_valid !== 1'b1) begin bad++; $display("FAIL full_head got=%h exp=%h", got, head); end
      end
      if (k > 5) begin
        total++; if (got !== head || out_valid !== 1'b1) begin bad++; $display("FAIL full_stable k=%0d got=%h exp=%h", k, got, head); end
      end
    end
    total++; if (accepted != DEPTH) begin bad++; $display("FAIL full_accepted got=%0d exp=%0d", accepted, DEPTH); end
    out_ready = 1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_pop_cycle_ready got=%b exp=0", issue_ready); end
    tick();
    out_ready = 0;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_credit_return got=%b exp=1", issue_ready); end
    tick();
    issue_valid = 0; out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      total++; if (out_valid !== (expq.size() > 0) || got !== exp_head()) begin bad++; $display("FAIL full_order k=%0d got=%b/%h exp=%h", k, out_valid, got, exp_head()); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1; issue_valid = 1;
    for (int k = 0; k < 24; k++) begin
      x = {pick(), pick(), 11'(k + 1)};
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, issue_ready); end
      tick();
      if (k >= 2) begin
        total++; if (out_valid !== 1'b1 || out_act0 !== 10'(k - 1)) begin bad++; $display("FAIL b2b_stream k=%0d got=%b/%0d exp=1/%0d", k, out_valid, out_act0, k - 1); end
      end
      total++; if (got !== exp_head() || sample_cnt !== m_samp) begin bad++; $display("FAIL b2b_model k=%0d got=%h/%0d exp=%h/%0d", k, got, sample_cnt, exp_head(), m_samp); end
    end
    issue_valid = 0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      issue_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      x = {pick(), pick(), pick()};
      tick();
      total++;
      if (out_valid !== (expq.size() > 0) || got !== exp_head() || issue_ready !== exp_ready() ||
          sample_cnt !== m_samp || sat_cnt !== 16'(m_sat)) begin
        bad++;
        $display("FAIL random k=%0d got v=%b d=%h r=%b sc=%0d sat=%0d exp v=%b d=%h r=%b sc=%0d sat=%0d", k,
                 out_valid, got, issue_ready, sample_cnt, sat_cnt, expq.size() > 0, exp_head(), exp_ready(), m_samp, m_sat);
      end
    end
    issue_valid = 0; out_ready = 1;
    repeat (6) tick();
  endtask

  task automatic test_mid_reset();
    rst = 1; tick(); rst = 0;
    out_ready = 0; issue_valid = 1;
    repeat (2) begin x = {11'd7, 11'd8, 11'd9}; tick(); end
    issue_valid = 0;
    repeat (2) tick();
    issue_valid = 1; x = {11'd2047, 11'd2047, 11'd2047};
    repeat (2) tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_buffered got=%b exp=1", out_valid); end
    issue_valid = 0; rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b0 || issue_ready !== 1'b1 || sample_cnt !== 16'd0 || sat_cnt !== 16'd0) begin
        bad++;
        $display("FAIL midrst k=%0d got v=%b r=%b sc=%0d sat=%0d exp 0/1/0/0", k, out_valid, issue_ready, sample_cnt, sat_cnt);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    rst = 1; tick(); rst = 0;
    out_ready = 1; issue_valid = 1; x = {11'd2047, 11'd1024, 11'd1500};
    repeat (65536) tick();
    issue_valid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (sample_cnt !== m_samp) begin bad++; $display("FAIL wrap_model k=%0d got=%0d exp=%0d", k, sample_cnt, m_samp); end
    end
    total++; if (sample_cnt !== 16'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL wrap_sample got=%0d/%b exp=0/0", sample_cnt, out_valid); end
    total++; if (sat_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", sat_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_sat();
    test_full();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
